// File: rtl/bcd_pkg.sv
// Shared types and defaults for the sequential BCD-to-binary converter.
// Holds the FSM state encoding and the per-nibble reverse double-dabble correction.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    localparam int BCD_DIGITS = 7;
    localparam int BCD_BIN_W  = 24;

    // A nibble that lands on 8..15 after the right shift carried a decimal
    // "ten" down into it; subtracting 3 restores a valid BCD digit.
    function automatic logic [3:0] nib_corr(input logic [3:0] v);
        return (v >= 4'd8) ? v - 4'd3 : v;
    endfunction

endpackage

// File: rtl/bcd_binary_seq_if.sv
// Request/result bundle of the BCD-to-binary converter.
// The master issues start/bcd; the slave (converter) returns bin and status.
interface bcd_binary_seq_if
    import bcd_pkg::*;
#(
    parameter int BUS_BCD = 4 * BCD_DIGITS,
    parameter int BUS_BIN = BCD_BIN_W
);
    logic               start;
    logic [BUS_BCD-1:0] bcd;
    logic [BUS_BIN-1:0] bin;
    logic               busy;
    logic               done;
    logic               ovf;
    logic               err;

    modport master (output start, bcd, input bin, busy, done, ovf, err);
    modport slave  (input start, bcd, output bin, busy, done, ovf, err);
endinterface

// File: rtl/bcd_rshift_stage.sv
// One reverse double-dabble step: shift {bcd_field, bin_field} right by one,
// then correct every BCD nibble in parallel.
module bcd_rshift_stage
    import bcd_pkg::*;
#(
    parameter int DIGITS  = BCD_DIGITS,
    parameter int BUS_BIN = BCD_BIN_W
) (
    input  logic [4*DIGITS+BUS_BIN-1:0] sr_in,
    output logic [4*DIGITS+BUS_BIN-1:0] sr_out
);
    logic [4*DIGITS+BUS_BIN-1:0] shifted;

    // NOTE: combinational logic uses blocking assignments and gives every
    // output a full default first, so no latch can be inferred.
    always_comb begin
        shifted = sr_in >> 1;
        sr_out  = shifted;
        for (int i = 0; i < DIGITS; i++) begin
            sr_out[BUS_BIN+4*i +: 4] = nib_corr(shifted[BUS_BIN+4*i +: 4]);
        end
    end
endmodule

// File: rtl/bcd_binary_seq.sv
// Sequential BCD-to-binary converter, one reverse double-dabble step per cycle.
// Define BCD_DIGIT_CHECK_EN to reject operands containing a digit above 9.
module bcd_binary_seq
    import bcd_pkg::*;
#(
    parameter int DIGITS  = BCD_DIGITS,
    parameter int BUS_BCD = 4 * DIGITS,
    parameter int BUS_BIN = BCD_BIN_W
) (
    input  logic             clk,
    input  logic             rst_n,
    bcd_binary_seq_if.slave  bus
);
    localparam int                SR_W     = BUS_BCD + BUS_BIN;
    localparam int                CNT_W    = $clog2(BUS_BIN + 1);
    localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(BUS_BIN);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(1);

    state_t            state;
    logic [SR_W-1:0]   sr;
    logic [SR_W-1:0]   sr_nxt;
    logic [CNT_W-1:0]  cnt;
    logic              digit_bad;

    bcd_rshift_stage #(
        .DIGITS  (DIGITS),
        .BUS_BIN (BUS_BIN)
    ) u_stage (
        .sr_in  (sr),
        .sr_out (sr_nxt)
    );

`ifdef BCD_DIGIT_CHECK_EN
    always_comb begin
        digit_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bus.bcd[4*i +: 4] > 4'd9) digit_bad = 1'b1;
        end
    end
`else
    assign digit_bad = 1'b0;
`endif

    // NOTE: all state is updated with non-blocking assignments so every
    // register samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            sr       <= '0;
            cnt      <= '0;
            bus.bin  <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.ovf  <= 1'b0;
            bus.err  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (digit_bad) begin
                            // Rejected operand: report immediately, no shifting.
                            state    <= DONE;
                            bus.done <= 1'b1;
                            bus.bin  <= '0;
                            bus.ovf  <= 1'b0;
                            bus.err  <= 1'b1;
                        end else begin
                            state    <= SHIFT;
                            sr       <= {bus.bcd, {BUS_BIN{1'b0}}};
                            cnt      <= CNT_INIT;
                            bus.busy <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    sr  <= sr_nxt;
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_LAST) begin
                        // Residual decimal value after the final shift means
                        // the result does not fit in BUS_BIN bits.
                        state    <= DONE;
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                        bus.bin  <= sr_nxt[BUS_BIN-1:0];
                        bus.ovf  <= |sr_nxt[SR_W-1:BUS_BIN];
                        bus.err  <= 1'b0;
                    end
                end
                DONE: begin
                    bus.done <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bcd_binary_seq.sv
// Self-checking bench for bcd_binary_seq: decimal-arithmetic reference model,
// per-cycle comparison, directed literal cases and randomized conversions.
module tb_bcd_binary_seq;
    localparam int BB  = 24;
    localparam int BB2 = 20;
`ifdef BCD_DIGIT_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bcd_binary_seq_if #(.BUS_BCD(28), .BUS_BIN(BB))  m_if ();
    bcd_binary_seq_if #(.BUS_BCD(28), .BUS_BIN(BB2)) s_if ();

    bcd_binary_seq dut (.clk(clk), .rst_n(rst_n), .bus(m_if));
    bcd_binary_seq #(.BUS_BIN(BB2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(s_if));

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint bcd_value(input logic [27:0] v);
        longint acc = 0;
        for (int i = 6; i >= 0; i--) acc = acc * 10 + longint'(v[4*i +: 4]);
        return acc;
    endfunction

    function automatic bit bcd_bad(input logic [27:0] v);
        for (int i = 0; i < 7; i++) if (v[4*i +: 4] > 4'd9) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [27:0] rand_bcd();
        logic [27:0] v = '0;
        for (int i = 0; i < 7; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
        return v;
    endfunction

    // Reference model: edge counter plus the scheduled done/busy windows and results.
    int      ecnt, m_free, m_done_at, m_busy_lo, m_busy_hi;
    longint  p_bin, h_bin;
    bit      p_ovf, p_err, p_known, h_ovf, h_err, h_known;
    bit      chk_en = 1'b0;

    always @(posedge clk or negedge rst_n) begin : model
        int     e;
        longint val;
        if (!rst_n) begin
            ecnt <= 0; m_free <= 0; m_done_at <= -1; m_busy_lo <= 1; m_busy_hi <= 0;
            h_bin <= 0; h_ovf <= 0; h_err <= 0; h_known <= 1;
        end else begin
            e = ecnt + 1;
            ecnt <= e;
            if (e == m_done_at) begin
                h_bin <= p_bin; h_ovf <= p_ovf; h_err <= p_err; h_known <= p_known;
            end
            if (m_if.start && e >= m_free) begin
                if (CHK && bcd_bad(m_if.bcd)) begin
                    m_done_at <= e; m_free <= e + 2;
                    h_bin <= 0; h_ovf <= 0; h_err <= 1; h_known <= 1;
                end else begin
                    val = bcd_value(m_if.bcd);
                    m_done_at <= e + BB; m_free <= e + BB + 2;
                    m_busy_lo <= e; m_busy_hi <= e + BB - 1;
                    p_bin <= val % (longint'(1) << BB);
                    p_ovf <= (val >> BB) != 0;
                    p_err <= 0;
                    p_known <= !bcd_bad(m_if.bcd);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            check("busy", m_if.busy, (ecnt >= m_busy_lo) && (ecnt <= m_busy_hi));
            check("done", m_if.done, ecnt == m_done_at);
            check("err", m_if.err, h_err);
            if (h_known) begin
                check("bin", m_if.bin, h_bin);
                check("ovf", m_if.ovf, h_ovf);
            end
        end
    end

    task automatic conv(input logic [27:0] v, output int lat, output int nbusy);
        @(negedge clk);
        m_if.start = 1'b1;
        m_if.bcd   = v;
        @(negedge clk);
        m_if.start = 1'b0;
        lat = 1;
        nbusy = 0;
        while (!m_if.done && lat < 60) begin
            if (m_if.busy) nbusy++;
            @(negedge clk);
            lat++;
        end
        if (!m_if.done) check("done_timeout", 0, 1);
    endtask

    initial begin
        int lat, nb;
        logic [27:0] v;
        m_if.start = 1'b0; m_if.bcd = '0;
        s_if.start = 1'b0; s_if.bcd = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_bin", m_if.bin, 0);
        check("rst_busy", m_if.busy, 0);
        check("rst_done", m_if.done, 0);
        check("rst_flags", {m_if.ovf, m_if.err}, 0);
        chk_en = 1'b1;

        conv(28'h0000123, lat, nb);
        check("lat_123", lat, BB + 1);
        check("busy_cycles_123", nb, BB);
        check("bin_123", m_if.bin, 24'h00007B);
        check("ovf_123", {m_if.ovf, m_if.err}, 0);

        conv(28'h9999999, lat, nb);
        check("bin_9999999", m_if.bin, 24'h98967F);
        check("ovf_9999999", m_if.ovf, 0);

        // Narrow instance: 9999999 does not fit in 20 bits.
        @(negedge clk);
        s_if.start = 1'b1; s_if.bcd = 28'h9999999;
        @(negedge clk);
        s_if.start = 1'b0;
        lat = 1;
        while (!s_if.done && lat < 60) begin @(negedge clk); lat++; end
        check("lat_w20", lat, BB2 + 1);
        check("ovf_w20", s_if.ovf, 1);
        check("bin_w20", s_if.bin, 20'h8967F);

        conv(28'h0000000, lat, nb);
        check("lat_zero", lat, BB + 1);
        check("bin_zero", m_if.bin, 0);
        conv(28'h4194303, lat, nb);
        check("lat_b2b", lat, BB + 1);
        check("bin_b2b", m_if.bin, 24'h3FFFFF);

        // start held and bcd changed during conversion must be ignored.
        @(negedge clk);
        m_if.start = 1'b1; m_if.bcd = 28'h0000123;
        @(negedge clk);
        m_if.bcd = 28'h0000001;
        lat = 1;
        while (!m_if.done && lat < 60) begin @(negedge clk); lat++; end
        m_if.start = 1'b0;
        check("lat_held", lat, BB + 1);
        check("bin_held", m_if.bin, 24'h00007B);
        repeat (2) @(negedge clk);

        conv(28'h00000A0, lat, nb);
`ifdef BCD_DIGIT_CHECK_EN
        check("lat_bad", lat, 1);
        check("err_bad", m_if.err, 1);
        check("bin_bad", m_if.bin, 0);
`else
        check("lat_bad", lat, BB + 1);
        check("err_bad", m_if.err, 0);
`endif
        conv(28'h0000777, lat, nb);
        check("bin_777", m_if.bin, 24'h000309);

        // Abort mid-conversion with reset.
        @(negedge clk);
        m_if.start = 1'b1; m_if.bcd = 28'h9999999;
        @(negedge clk);
        m_if.start = 1'b0;
        repeat (9) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", m_if.busy, 0);
        check("abort_done", m_if.done, 0);
        check("abort_bin", m_if.bin, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        conv(28'h0000050, lat, nb);
        check("bin_50", m_if.bin, 24'h000032);

        for (int k = 0; k < 40; k++) begin
            int hold, pos;
            v = rand_bcd();
            if ($urandom_range(0, 7) == 0) begin
                pos = $urandom_range(0, 6);
                v[4*pos +: 4] = 4'($urandom_range(10, 15));
            end
            hold = $urandom_range(1, 30);
            @(negedge clk);
            m_if.start = 1'b1; m_if.bcd = v;
            repeat (hold) begin @(negedge clk); m_if.bcd = rand_bcd(); end
            m_if.start = 1'b0;
            repeat ($urandom_range(BB + 3, BB + 6)) @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
